// File: rtl/uart_tx.sv
// UART transmitter: pulls bytes from a FIFO read port and shifts them out LSB first.
// Runtime baud divisor, optional even/odd parity, one or two stop bits.
module uart_tx #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             srst,
  input  logic             r_valid,
  output logic             r_ready,
  input  logic [7:0]       r_data,
  input  logic [DIV_W-1:0] divisor,
  input  logic             parity_en,
  input  logic             parity_odd,
  input  logic             stop2,
  output logic             tx,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] baud_q, baud_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       bit_q, bit_d;
  logic             stop_q, stop_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic             par_en_q, par_en_d;
  logic             stop2_q, stop2_d;
  logic             busy_q, busy_d;

  logic accept;
  logic bit_end;

  assign r_ready = (state_q == S_IDLE) & ~srst & ~rst;
  assign accept  = r_valid & r_ready;
  // Counting 0..div_q inclusive gives div+1 clocks per bit without overflow at max divisor.
  assign bit_end = (baud_q == div_q);

  // NOTE: every signal gets a default first so no path through the case leaves a latch.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    div_d    = div_q;
    bit_d    = bit_q;
    stop_d   = stop_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    par_en_d = par_en_q;
    stop2_d  = stop2_q;

    if (state_q != S_IDLE) begin
      baud_d = bit_end ? '0 : baud_q + DIV_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d  = S_START;
          baud_d   = '0;
          shift_d  = r_data;
          div_d    = divisor;
          par_en_d = parity_en;
          stop2_d  = stop2;
          parity_d = (^r_data) ^ parity_odd;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          stop_d  = 1'b0;
          if (bit_q == 3'd7) begin
            state_d = par_en_q ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          stop_d  = 1'b0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (stop2_q && !stop_q) begin
            stop_d = 1'b1;
          end else begin
            state_d = S_IDLE;
            stop_d  = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Soft reset drops any frame in progress; the byte is not re-requested.
    if (srst) begin
      state_d  = S_IDLE;
      baud_d   = '0;
      div_d    = '0;
      bit_d    = '0;
      stop_d   = 1'b0;
      shift_d  = '0;
      parity_d = 1'b0;
      par_en_d = 1'b0;
      stop2_d  = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      div_q    <= '0;
      bit_q    <= '0;
      stop_q   <= 1'b0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      par_en_q <= 1'b0;
      stop2_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      stop_q   <= stop_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      par_en_q <= par_en_d;
      stop2_q  <= stop2_d;
      busy_q   <= busy_d;
    end
  end

  // tx decodes straight from the state register, so an async rst idles the line at once.
  always_comb begin
    tx = 1'b1;
    case (state_q)
      S_START:  tx = 1'b0;
      S_DATA:   tx = shift_q[0];
      S_PARITY: tx = parity_q;
      default:  tx = 1'b1;
    endcase
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: FIFO source model plus a per-clock tx scoreboard.
module tb_uart_tx;

  localparam int DIV_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             srst;
  logic             r_valid = 1'b0;
  logic             r_ready;
  logic [7:0]       r_data = 8'h00;
  logic [DIV_W-1:0] divisor;
  logic             parity_en;
  logic             parity_odd;
  logic             stop2;
  logic             tx;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;
  int busy_cnt = 0;
  int accept_cnt = 0;
  int neg_cnt = 0;
  bit pop_pending = 1'b0;

  logic [7:0] src_q[$];
  bit         exp_q[$];
  int         acc_cyc[$];

  uart_tx #(.DIV_W(DIV_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .srst      (srst),
    .r_valid   (r_valid),
    .r_ready   (r_ready),
    .r_data    (r_data),
    .divisor   (divisor),
    .parity_en (parity_en),
    .parity_odd(parity_odd),
    .stop2     (stop2),
    .tx        (tx),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Expected tx level for every clock of a frame, using the config seen at accept.
  task automatic push_frame(input logic [7:0] d);
    bit bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (parity_en) bits.push_back((^d) ^ parity_odd);
    bits.push_back(1'b1);
    if (stop2) bits.push_back(1'b1);
    foreach (bits[i]) begin
      for (int c = 0; c <= int'(divisor); c++) exp_q.push_back(bits[i]);
    end
  endtask

  // Monitor then FIFO driver, both on the falling edge, away from the active edge.
  always @(negedge clk) begin
    bit e;
    neg_cnt++;
    if (busy) begin
      busy_cnt++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_underflow: busy=1 with no expected bit at cycle %0d", neg_cnt);
      end else begin
        e = exp_q.pop_front();
        if (tx !== e) begin
          n_fail++;
          $display("FAIL sb_tx: tx=%b expected %b at cycle %0d", tx, e, neg_cnt);
        end
      end
      n_checks++;
      if (r_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL ready_busy: r_ready=%b expected 0 at cycle %0d", r_ready, neg_cnt);
      end
    end else begin
      n_checks++;
      if (tx !== 1'b1) begin
        n_fail++;
        $display("FAIL idle_tx: tx=%b expected 1 at cycle %0d", tx, neg_cnt);
      end
    end

    if (pop_pending) begin
      void'(src_q.pop_front());
      pop_pending = 1'b0;
    end
    r_valid = (src_q.size() != 0);
    r_data  = r_valid ? src_q[0] : 8'h00;
    if (r_valid && r_ready) begin
      accept_cnt++;
      acc_cyc.push_back(neg_cnt);
      push_frame(r_data);
      pop_pending = 1'b1;
    end
  end

  task automatic wait_idle(input int budget, input string name);
    int i;
    for (i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (src_q.size() == 0 && !busy && exp_q.size() == 0) break;
    end
    n_checks++;
    if (i == budget) begin
      n_fail++;
      $display("FAIL %s_timeout: not idle after %0d cycles (busy=%b, %0d bits left)",
               name, budget, busy, exp_q.size());
    end
  endtask

  task automatic wait_busy(input string name);
    int i;
    for (i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (busy) break;
    end
    n_checks++;
    if (i == 100) begin
      n_fail++;
      $display("FAIL %s_start_timeout: busy=%b expected 1", name, busy);
    end
  endtask

  task automatic set_cfg(input int div, input logic pe, input logic po, input logic s2);
    divisor    = DIV_W'(div);
    parity_en  = pe;
    parity_odd = po;
    stop2      = s2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      n_checks++;
      if (tx !== 1'b1 || busy !== 1'b0 || r_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold: tx=%b busy=%b r_ready=%b expected 1/0/0", tx, busy, r_ready);
      end
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (r_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: r_ready=%b expected 1", r_ready);
    end
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || accept_cnt !== 0) begin
      n_fail++;
      $display("FAIL reset_idle: tx=%b busy=%b accepts=%0d expected 1/0/0", tx, busy, accept_cnt);
    end
  endtask

  task automatic test_single();
    set_cfg(3, 1'b0, 1'b0, 1'b0);
    busy_cnt = 0;
    src_q.push_back(8'hA5);
    wait_idle(200, "single");
    n_checks++;
    if (busy_cnt !== 40) begin
      n_fail++;
      $display("FAIL single_len: busy for %0d clocks expected 40", busy_cnt);
    end
  endtask

  task automatic parity_case(input logic po, input logic s2, input logic exp_par, input int exp_len);
    set_cfg(0, 1'b1, po, s2);
    busy_cnt = 0;
    src_q.push_back(8'h07);
    wait_busy("parity");
    repeat (9) @(posedge clk);
    #1;
    n_checks++;
    if (tx !== exp_par) begin
      n_fail++;
      $display("FAIL parity_bit(odd=%b): tx=%b expected %b", po, tx, exp_par);
    end
    wait_idle(100, "parity");
    n_checks++;
    if (busy_cnt !== exp_len) begin
      n_fail++;
      $display("FAIL parity_len(stop2=%b): %0d clocks expected %0d", s2, busy_cnt, exp_len);
    end
  endtask

  task automatic test_parity();
    parity_case(1'b0, 1'b0, 1'b1, 11);
    parity_case(1'b1, 1'b0, 1'b0, 11);
    parity_case(1'b0, 1'b1, 1'b1, 12);
  endtask

  task automatic test_back_to_back();
    int a0;
    set_cfg(1, 1'b0, 1'b0, 1'b0);
    busy_cnt = 0;
    a0 = accept_cnt;
    acc_cyc.delete();
    src_q.push_back(8'h00);
    src_q.push_back(8'hFF);
    wait_idle(200, "b2b");
    n_checks++;
    if (accept_cnt - a0 !== 2) begin
      n_fail++;
      $display("FAIL b2b_accepts: %0d expected 2", accept_cnt - a0);
    end
    n_checks++;
    if (busy_cnt !== 40) begin
      n_fail++;
      $display("FAIL b2b_len: busy for %0d clocks expected 40", busy_cnt);
    end
    n_checks++;
    if (acc_cyc.size() != 2 || acc_cyc[1] - acc_cyc[0] != 21) begin
      n_fail++;
      $display("FAIL b2b_period: %0d accepts recorded, period %0d expected 21",
               acc_cyc.size(), (acc_cyc.size() == 2) ? acc_cyc[1] - acc_cyc[0] : -1);
    end
  endtask

  task automatic test_cfg_change();
    set_cfg(2, 1'b0, 1'b0, 1'b0);
    busy_cnt = 0;
    src_q.push_back(8'h3C);
    wait_busy("cfg");
    repeat (6) @(posedge clk);
    #1;
    divisor = DIV_W'(5);
    wait_idle(200, "cfg1");
    n_checks++;
    if (busy_cnt !== 30) begin
      n_fail++;
      $display("FAIL cfg_first_len: %0d clocks expected 30", busy_cnt);
    end
    busy_cnt = 0;
    src_q.push_back(8'hC3);
    wait_idle(200, "cfg2");
    n_checks++;
    if (busy_cnt !== 60) begin
      n_fail++;
      $display("FAIL cfg_second_len: %0d clocks expected 60", busy_cnt);
    end
  endtask

  task automatic test_abort();
    int a0;
    set_cfg(3, 1'b0, 1'b0, 1'b0);
    src_q.push_back(8'h5A);
    wait_busy("abort");
    repeat (21) @(posedge clk);
    #1;
    srst = 1'b1;
    src_q.push_back(8'h81);
    a0 = accept_cnt;
    @(posedge clk); #1;
    n_checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || r_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle: tx=%b busy=%b r_ready=%b expected 1/0/0", tx, busy, r_ready);
    end
    srst = 1'b0;
    exp_q.delete();
    busy_cnt = 0;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b1 || tx !== 1'b0 || accept_cnt - a0 !== 1) begin
      n_fail++;
      $display("FAIL abort_reaccept: busy=%b tx=%b accepts=%0d expected 1/0/1",
               busy, tx, accept_cnt - a0);
    end
    wait_idle(200, "abort");
    n_checks++;
    if (busy_cnt !== 40) begin
      n_fail++;
      $display("FAIL abort_next_len: %0d clocks expected 40", busy_cnt);
    end
  endtask

  initial begin
    rst  = 1'b1;
    srst = 1'b0;
    set_cfg(0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_single();
    test_parity();
    test_back_to_back();
    test_cfg_change();
    test_abort();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0 || src_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover: %0d expected bits, %0d source bytes, expected 0/0",
               exp_q.size(), src_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
